// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: opcodes and FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  // ADD and SUB are the only opcodes that propagate a carry
  function automatic logic is_arith(input op_t o);
    return (o == OP_ADD) || (o == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: AND / OR / full-add candidates picked by a 4->1 mux on op.
// SUB arrives here as an ADD with b already inverted by the caller.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       r,
  output logic       cout
);

  logic and_v;
  logic or_v;
  logic sum_v;

  always_comb begin
    and_v = a & b;
    or_v  = a | b;
    sum_v = a ^ b ^ cin;
    cout  = (a & b) | (cin & (a ^ b));
    r     = sum_v;
    case (op)
      OP_AND:  r = and_v;
      OP_OR:   r = or_v;
      OP_ADD:  r = sum_v;
      OP_SUB:  r = sum_v;
      default: r = sum_v;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: LSB-first, one bit per clock, valid/ready on both sides.
// Optional zero/ovf flag outputs are built when ALU_SEQ_FLAGS_EN is defined.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic             accept;
  logic             step;
  logic             last;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  op_t              op_q;
  logic             carry_q;
  logic             slice_b;
  logic             slice_r;
  logic             slice_cout;
  logic             carry_nxt;
  logic [WIDTH-1:0] result_nxt;

  assign in_ready = (state_q == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count_q == CNT_LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign slice_b    = b_sh[0] ^ (op_q == OP_SUB);
  assign carry_nxt  = is_arith(op_q) ? slice_cout : carry_q;
  assign result_nxt = {slice_r, result[WIDTH-1:1]};

  alu_bit_slice u_slice (
    .a    (a_sh[0]),
    .b    (slice_b),
    .cin  (carry_q),
    .op   (op_q),
    .r    (slice_r),
    .cout (slice_cout)
  );

  // Operand/result shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      op_q      <= OP_AND;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zero      <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= (state_d == DONE);
      if (accept) begin
        a_sh    <= a;
        b_sh    <= b;
        op_q    <= op_t'(op);
        count_q <= '0;
        carry_q <= (op_t'(op) == OP_SUB);
      end
      if (step) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        result  <= result_nxt;
        carry_q <= carry_nxt;
        if (!last) count_q <= count_q + CNT_W'(1);
        if (last) begin
          carry_out <= carry_nxt;
`ifdef ALU_SEQ_FLAGS_EN
          zero      <= (result_nxt == '0);
          // carry_q is the carry into the MSB on the final step
          ovf       <= is_arith(op_q) & (carry_q ^ slice_cout);
`endif
        end
      end
    end
  end

endmodule
